// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage control, memory and instruction-register signals
interface instruction_fetch_if;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr_data;
  logic        ir_we;
  logic [31:0] fetch_pc;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    input  fetch_en, redirect, redirect_pc, mem_ready, mem_rdata,
    output mem_req, mem_addr, instr_data, ir_we, fetch_pc, busy, fault, fault_code
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, mem_ready, mem_rdata,
    input  mem_req, mem_addr, instr_data, ir_we, fetch_pc, busy, fault, fault_code
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - multicycle fetch stage: PC owner, memory handshake, IR write pulse
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_fetch_if.master    bus
);
  typedef enum logic [1:0] {IDLE, REQ, FAULT} state_t;

  // Counter value at which one more empty REQ cycle means the timeout is reached.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] fpc_q, fpc_nxt;
  logic        we_q, we_nxt;
  logic [1:0]  code_q, code_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      cnt     <= 8'd0;
      instr_q <= 32'd0;
      fpc_q   <= 32'd0;
      we_q    <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cnt     <= cnt_nxt;
      instr_q <= instr_nxt;
      fpc_q   <= fpc_nxt;
      we_q    <= we_nxt;
      code_q  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    instr_nxt = instr_q;
    fpc_nxt   = fpc_q;
    we_nxt    = 1'b0;
    code_nxt  = code_q;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          if (bus.redirect_pc[1:0] == 2'b00) begin
            pc_nxt = bus.redirect_pc;
          end else begin
            state_nxt = FAULT;
            code_nxt  = 2'b01;
          end
        end else if (bus.fetch_en) begin
          state_nxt = REQ;
          cnt_nxt   = 8'd0;
        end
      end
      REQ: begin
        // Redirect wins over a concurrent beat or timeout; the beat is dropped.
        if (bus.redirect) begin
          if (bus.redirect_pc[1:0] == 2'b00) begin
            pc_nxt    = bus.redirect_pc;
            state_nxt = IDLE;
          end else begin
            state_nxt = FAULT;
            code_nxt  = 2'b01;
          end
        end else if (bus.mem_ready) begin
          instr_nxt = bus.mem_rdata;
          fpc_nxt   = pc;
          pc_nxt    = pc + 32'd4;
          we_nxt    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = FAULT;
          code_nxt  = 2'b10;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = FAULT;
      end
    endcase
  end

  // Request and status decode straight from state so reset drops them without a clock.
  assign bus.mem_req    = (state == REQ);
  assign bus.busy       = (state == REQ);
  assign bus.fault      = (state == FAULT);
  assign bus.mem_addr   = pc;
  assign bus.instr_data = instr_q;
  assign bus.fetch_pc   = fpc_q;
  assign bus.ir_we      = we_q;
  assign bus.fault_code = code_q;
endmodule
